// File: rtl/tim_ctrl_if.sv
// Peripheral bus bundle for tim_ctrl: single-cycle strobe, registered read return.
interface tim_ctrl_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    logic              bus_sel;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;

    modport master (output bus_sel, bus_we, bus_addr, bus_wdata,
                    input  bus_rdata, bus_rvalid);
    modport slave  (input  bus_sel, bus_we, bus_addr, bus_wdata,
                    output bus_rdata, bus_rvalid);
endinterface

// File: rtl/tim_ctrl.sv
// Register file, start/stop sequencing and shadow transfers for the 16-bit prescaled timer.
// Optional input capture is compiled in with TIM_CTRL_CAPTURE_EN.
module tim_ctrl #(
    parameter int unsigned      CNT_W   = 16,
    parameter logic [CNT_W-1:0] PSC_RST = '0,
    parameter logic [CNT_W-1:0] ARR_RST = '1
) (
    input  logic             clk,
    input  logic             rst,
    tim_ctrl_if.slave        bus,
    output logic             tim_en,
    output logic             tim_countdown,
    output logic [CNT_W-1:0] tim_psc,
    output logic [CNT_W-1:0] tim_arr,
    output logic             tim_reload,
    input  logic [CNT_W-1:0] tim_cnt,
    input  logic             tim_evt,
    input  logic             cap_in,
    output logic             irq
);
    localparam int unsigned DATA_W = 32;
    localparam logic [2:0] A_CR   = 3'd0;
    localparam logic [2:0] A_DIER = 3'd1;
    localparam logic [2:0] A_SR   = 3'd2;
    localparam logic [2:0] A_EGR  = 3'd3;
    localparam logic [2:0] A_PSC  = 3'd4;
    localparam logic [2:0] A_ARR  = 3'd5;
    localparam logic [2:0] A_CNT  = 3'd6;
    localparam logic [2:0] A_CCR  = 3'd7;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
    state_t state, state_nxt;

    logic             cen, dir, opm, arpe, uie, ccie, uif, ccif;
    logic             cen_nxt, uie_nxt, ccie_nxt, uif_nxt, ccif_nxt;
    logic             wr, rd, wr_cr, wr_dier, wr_sr, wr_psc, wr_arr, ug;
    logic             evt_q, evt_rise, uev, arm_entry;
    logic [CNT_W-1:0] psc_pre, arr_pre, psc_act, arr_act, ccr;
    logic [DATA_W-1:0] rd_mux;
    logic             unused_ok;

    assign wr       = bus.bus_sel & bus.bus_we;
    assign rd       = bus.bus_sel & ~bus.bus_we;
    assign wr_cr    = wr & (bus.bus_addr == A_CR);
    assign wr_dier  = wr & (bus.bus_addr == A_DIER);
    assign wr_sr    = wr & (bus.bus_addr == A_SR);
    assign wr_psc   = wr & (bus.bus_addr == A_PSC);
    assign wr_arr   = wr & (bus.bus_addr == A_ARR);
    assign ug       = wr & (bus.bus_addr == A_EGR) & bus.bus_wdata[0];
    assign evt_rise = tim_evt & ~evt_q;
    assign uev      = evt_rise | ug;
    assign uie_nxt  = wr_dier ? bus.bus_wdata[0] : uie;
    assign ccie_nxt = wr_dier ? bus.bus_wdata[1] : ccie;
    assign arm_entry = (state_nxt == ARM);

    // Next-state and next flag values; OPM clear and flag set take priority
    always_comb begin
        state_nxt = state;
        cen_nxt   = cen;
        uif_nxt   = uif;
        if (wr_cr) cen_nxt = bus.bus_wdata[0];
        if (uev && opm) cen_nxt = 1'b0;
        if (wr_sr && bus.bus_wdata[0]) uif_nxt = 1'b0;
        if (uev) uif_nxt = 1'b1;
        case (state)
            IDLE:    if (cen) state_nxt = ARM;
            ARM:     state_nxt = cen_nxt ? RUN : IDLE;
            RUN:     if (!cen) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            A_CR:    rd_mux = DATA_W'({arpe, opm, dir, cen});
            A_DIER:  rd_mux = DATA_W'({ccie, uie});
            A_SR:    rd_mux = DATA_W'({ccif, uif});
            A_EGR:   rd_mux = '0;
            A_PSC:   rd_mux = DATA_W'(psc_pre);
            A_ARR:   rd_mux = DATA_W'(arr_pre);
            A_CNT:   rd_mux = DATA_W'(tim_cnt);
            A_CCR:   rd_mux = DATA_W'(ccr);
            default: rd_mux = '0;
        endcase
    end

`ifdef TIM_CTRL_CAPTURE_EN
    logic cap_s1, cap_s2, cap_q, cap_evt;

    assign cap_evt  = cap_s2 & ~cap_q;
    assign ccif_nxt = cap_evt | (ccif & ~(wr_sr & bus.bus_wdata[1]));

    // Synchronize the external trigger and latch the count on its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_s1 <= 1'b0;
            cap_s2 <= 1'b0;
            cap_q  <= 1'b0;
            ccr    <= '0;
            ccif   <= 1'b0;
        end else begin
            cap_s1 <= cap_in;
            cap_s2 <= cap_s1;
            cap_q  <= cap_s2;
            ccif   <= ccif_nxt;
            if (cap_evt) ccr <= tim_cnt;
        end
    end

    assign unused_ok = ^bus.bus_wdata;
`else
    assign ccr       = '0;
    assign ccif      = 1'b0;
    assign ccif_nxt  = 1'b0;
    assign unused_ok = ^{bus.bus_wdata, cap_in};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cen            <= 1'b0;
            dir            <= 1'b0;
            opm            <= 1'b0;
            arpe           <= 1'b0;
            uie            <= 1'b0;
            ccie           <= 1'b0;
            uif            <= 1'b0;
            evt_q          <= 1'b1;
            psc_pre        <= PSC_RST;
            psc_act        <= PSC_RST;
            arr_pre        <= ARR_RST;
            arr_act        <= ARR_RST;
            tim_en         <= 1'b0;
            tim_reload     <= 1'b0;
            irq            <= 1'b0;
            bus.bus_rdata  <= '0;
            bus.bus_rvalid <= 1'b0;
        end else begin
            state <= state_nxt;
            evt_q <= tim_evt;
            cen   <= cen_nxt;
            uif   <= uif_nxt;
            uie   <= uie_nxt;
            ccie  <= ccie_nxt;
            if (wr_cr) begin
                dir  <= bus.bus_wdata[1];
                opm  <= bus.bus_wdata[2];
                arpe <= bus.bus_wdata[3];
            end
            // Shadow transfers see the old preload; a same-cycle write lands afterwards
            if (uev || arm_entry) psc_act <= psc_pre;
            if (uev || arm_entry || !arpe) arr_act <= arr_pre;
            if (wr_psc) psc_pre <= bus.bus_wdata[CNT_W-1:0];
            if (wr_arr) arr_pre <= bus.bus_wdata[CNT_W-1:0];
            tim_en         <= (state_nxt == RUN) & cen_nxt;
            tim_reload     <= arm_entry | ug;
            irq            <= (uif_nxt & uie_nxt) | (ccif_nxt & ccie_nxt);
            bus.bus_rvalid <= rd;
            if (rd) bus.bus_rdata <= rd_mux;
        end
    end

    assign tim_countdown = dir;
    assign tim_psc       = psc_act;
    assign tim_arr       = arr_act;
endmodule

// File: tb/tb_tim_ctrl.sv
// Directed-sequence bench with randomized data for tim_ctrl, checked against a register-level model.
module tb_tim_ctrl;
    localparam int unsigned CNT_W = 16;
    localparam logic [2:0] A_CR = 3'd0, A_DIER = 3'd1, A_SR = 3'd2, A_EGR = 3'd3;
    localparam logic [2:0] A_PSC = 3'd4, A_ARR = 3'd5, A_CNT = 3'd6, A_CCR = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic             tim_en, tim_countdown, tim_reload, irq;
    logic [CNT_W-1:0] tim_psc, tim_arr, tim_cnt;
    logic             tim_evt, cap_in;

    tim_ctrl_if bus();

    tim_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .tim_en(tim_en), .tim_countdown(tim_countdown),
        .tim_psc(tim_psc), .tim_arr(tim_arr), .tim_reload(tim_reload),
        .tim_cnt(tim_cnt), .tim_evt(tim_evt), .cap_in(cap_in), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: CPU-visible registers and the active shadow values
    logic [CNT_W-1:0] m_psc_pre, m_arr_pre, m_psc_act, m_arr_act;
    logic [3:0]       m_cr;
    logic             m_uif, m_ccif, m_uie, m_ccie;

    function automatic logic m_irq();
        return (m_uif & m_uie) | (m_ccif & m_ccie);
    endfunction

    task automatic model_uev();
        m_psc_act = m_psc_pre;
        m_arr_act = m_arr_pre;
        m_uif     = 1'b1;
        if (m_cr[2]) m_cr[0] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        bus.bus_sel   = 1'b1;
        bus.bus_we    = 1'b1;
        bus.bus_addr  = a;
        bus.bus_wdata = d;
    endtask

    task automatic bus_idle();
        bus.bus_sel = 1'b0;
        bus.bus_we  = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        drive_wr(a, d);
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.bus_sel  = 1'b1;
        bus.bus_we   = 1'b0;
        bus.bus_addr = a;
        tick();
        bus_idle();
        chk("rvalid", 32'(bus.bus_rvalid), 32'd1);
        d = bus.bus_rdata;
    endtask

    task automatic wait_en(input int max);
        int n = 0;
        while (tim_en !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("en_wait", 32'(tim_en), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]      rdv;
        logic [31:0]      exp_rd;
        logic [CNT_W-1:0] p, a, p2, a2, p3, p4, p5, c;
        int               n;

        rst = 1'b1; tim_evt = 1'b1; cap_in = 1'b0;
        tim_cnt = CNT_W'($urandom);
        bus.bus_sel = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
        m_psc_pre = '0; m_psc_act = '0; m_arr_pre = '1; m_arr_act = '1;
        m_cr = '0; m_uif = 1'b0; m_ccif = 1'b0; m_uie = 1'b0; m_ccie = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset values, with tim_evt high across reset release
        chk("rst_en", 32'(tim_en), 32'd0);
        chk("rst_reload", 32'(tim_reload), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rvalid", 32'(bus.bus_rvalid), 32'd0);
        chk("rst_rdata", bus.bus_rdata, 32'd0);
        chk("rst_psc", 32'(tim_psc), 32'd0);
        chk("rst_arr", 32'(tim_arr), 32'h0000_FFFF);
        tick();
        tim_evt = 1'b0;

        for (int i = 0; i < 8; i++) begin
            case (i)
                5:       exp_rd = 32'h0000_FFFF;
                6:       exp_rd = 32'(tim_cnt);
                default: exp_rd = 32'd0;
            endcase
            bus_read(3'(i), rdv);
            chk($sformatf("rst_read%0d", i), rdv, exp_rd);
            tick();
            chk("rvalid_drop", 32'(bus.bus_rvalid), 32'd0);
        end

        // Preload writes; ARR follows while ARPE is clear, PSC does not
        p = CNT_W'($urandom); a = CNT_W'($urandom);
        bus_write(A_PSC, 32'(p)); m_psc_pre = p;
        bus_write(A_ARR, 32'(a)); m_arr_pre = a;
        tick(); m_arr_act = m_arr_pre;
        chk("pre_psc", 32'(tim_psc), 32'(m_psc_act));
        chk("pre_arr", 32'(tim_arr), 32'(m_arr_act));
        bus_read(A_PSC, rdv);
        chk("rd_psc", rdv, 32'(m_psc_pre));

        // Start: one ARM cycle with reload and fresh active values
        bus_write(A_CR, 32'h1); m_cr = 4'h1;
        n = 0;
        while (tim_reload !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        m_psc_act = m_psc_pre; m_arr_act = m_arr_pre;
        chk("arm_reload", 32'(tim_reload), 32'd1);
        chk("arm_psc", 32'(tim_psc), 32'(m_psc_act));
        chk("arm_arr", 32'(tim_arr), 32'(m_arr_act));
        chk("arm_en", 32'(tim_en), 32'd0);
        tick();
        chk("run_reload", 32'(tim_reload), 32'd0);
        chk("run_en", 32'(tim_en), 32'd1);

        // ARPE: ARR held until an update event; PSC write during the event lands after it
        bus_write(A_CR, 32'h9); m_cr = 4'h9;
        p2 = CNT_W'($urandom); a2 = CNT_W'($urandom);
        bus_write(A_PSC, 32'(p2)); m_psc_pre = p2;
        bus_write(A_ARR, 32'(a2)); m_arr_pre = a2;
        tick();
        chk("arpe_hold_arr", 32'(tim_arr), 32'(m_arr_act));
        chk("arpe_hold_psc", 32'(tim_psc), 32'(m_psc_act));
        p3 = CNT_W'($urandom);
        drive_wr(A_PSC, 32'(p3)); tim_evt = 1'b1;
        tick();
        bus_idle();
        model_uev(); m_psc_pre = p3;
        chk("uev_arr", 32'(tim_arr), 32'(m_arr_act));
        chk("uev_psc", 32'(tim_psc), 32'(m_psc_act));
        chk("uev_en", 32'(tim_en), 32'd1);
        bus_write(A_SR, 32'h1); m_uif = 1'b0;
        tick(); tick();
        tim_evt = 1'b0;
        tick();
        bus_read(A_SR, rdv);
        chk("level_once", rdv, 32'({m_ccif, m_uif}));
        chk("noirq", 32'(irq), 32'(m_irq()));

        // One-pulse mode: event clears CEN, raises irq; W1C drops it
        bus_write(A_DIER, 32'h1); m_uie = 1'b1;
        bus_write(A_CR, 32'h5); m_cr = 4'h5; m_arr_act = m_arr_pre;
        tim_evt = 1'b1;
        tick();
        tim_evt = 1'b0;
        model_uev();
        chk("opm_irq", 32'(irq), 32'(m_irq()));
        tick();
        chk("opm_en", 32'(tim_en), 32'd0);
        bus_read(A_CR, rdv);
        chk("opm_cr", rdv, 32'(m_cr));
        bus_read(A_SR, rdv);
        chk("opm_sr", rdv, 32'({m_ccif, m_uif}));
        bus_write(A_SR, 32'h1); m_uif = 1'b0;
        chk("w1c_irq", 32'(irq), 32'(m_irq()));

        // W1C against a simultaneous edge: set wins; event in IDLE still transfers PSC
        p4 = CNT_W'($urandom);
        bus_write(A_PSC, 32'(p4)); m_psc_pre = p4;
        drive_wr(A_SR, 32'h1); tim_evt = 1'b1;
        tick();
        bus_idle(); tim_evt = 1'b0;
        model_uev();
        chk("setwins_irq", 32'(irq), 32'(m_irq()));
        chk("idle_psc", 32'(tim_psc), 32'(m_psc_act));
        bus_read(A_SR, rdv);
        chk("setwins_sr", rdv, 32'({m_ccif, m_uif}));
        bus_write(A_SR, 32'h1); m_uif = 1'b0;

        // Software update generation
        p5 = CNT_W'($urandom);
        bus_write(A_PSC, 32'(p5)); m_psc_pre = p5;
        bus_write(A_EGR, 32'h1); model_uev();
        chk("ug_reload", 32'(tim_reload), 32'd1);
        chk("ug_psc", 32'(tim_psc), 32'(m_psc_act));
        chk("ug_irq", 32'(irq), 32'(m_irq()));
        tick();
        chk("ug_reload_end", 32'(tim_reload), 32'd0);
        bus_read(A_EGR, rdv);
        chk("egr_read", rdv, 32'd0);
        bus_read(A_SR, rdv);
        chk("ug_sr", rdv, 32'({m_ccif, m_uif}));
        bus_write(A_SR, 32'h1); m_uif = 1'b0;

        // Capture path
        bus_write(A_DIER, 32'h3); m_ccie = 1'b1;
        c = CNT_W'($urandom);
        tim_cnt = c;
        cap_in = 1'b1;
        repeat (5) tick();
        bus_read(A_CCR, rdv);
`ifdef TIM_CTRL_CAPTURE_EN
        m_ccif = 1'b1;
        chk("cap_ccr", rdv, 32'(c));
`else
        chk("cap_ccr", rdv, 32'd0);
`endif
        bus_read(A_SR, rdv);
        chk("cap_sr", rdv, 32'({m_ccif, m_uif}));
        chk("cap_irq", 32'(irq), 32'(m_irq()));
        cap_in = 1'b0;
        tim_cnt = CNT_W'($urandom);
        bus_read(A_CNT, rdv);
        chk("cnt_mirror", rdv, 32'(tim_cnt));
        bus_write(A_SR, 32'h3); m_ccif = 1'b0;

        // CEN write colliding with an OPM clear: clear wins
        bus_write(A_CR, 32'h5); m_cr = 4'h5;
        wait_en(6);
        drive_wr(A_CR, 32'h5); tim_evt = 1'b1;
        tick();
        bus_idle(); tim_evt = 1'b0;
        model_uev();
        bus_read(A_CR, rdv);
        chk("cen_vs_opm", rdv, 32'(m_cr));
        chk("cen_vs_opm_en", 32'(tim_en), 32'd0);

        // Reset in the middle of a run
        bus_write(A_CR, 32'h1);
        wait_en(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_en", 32'(tim_en), 32'd0);
        chk("mrst_reload", 32'(tim_reload), 32'd0);
        chk("mrst_irq", 32'(irq), 32'd0);
        chk("mrst_psc", 32'(tim_psc), 32'd0);
        chk("mrst_arr", 32'(tim_arr), 32'h0000_FFFF);
        bus_read(A_CR, rdv);
        chk("mrst_cr", rdv, 32'd0);
        bus_read(A_SR, rdv);
        chk("mrst_sr", rdv, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tim_ctrl.md
Name: tim_ctrl

Overview:
Bus-mapped control and scheduling block for the 16-bit prescaled timer core. It holds the CPU-visible registers: control, interrupt enable, status, event generation, prescaler, auto-reload, count mirror and capture. It sequences timer start and stop, performs preload-to-active shadow transfers on update events, and raises one combined interrupt line to the interrupt controller. It sits between the core's peripheral bus and the timer's enable, direction, PSC, ARR, count and interrupt pins.

Parameters:
CNT_W, 16, width of PSC, ARR, CNT and CCR.
PSC_RST, 0, reset value of the PSC preload and active registers.
ARR_RST, 16'hFFFF, reset value of the ARR preload and active registers.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
bus_sel  in  1  register access strobe, single cycle
bus_we  in  1  1 = write, 0 = read (qualified by bus_sel)
bus_addr  in  3  word address of the register
bus_wdata  in  32  write data
bus_rdata  out  32  read data, registered
bus_rvalid  out  1  high for one cycle, one cycle after a read strobe
tim_en  out  1  timer run enable
tim_countdown  out  1  count direction, mirrors CR.DIR
tim_psc  out  CNT_W  active prescaler value
tim_arr  out  CNT_W  active auto-reload value
tim_reload  out  1  one-cycle request to restart the timer count at 0
tim_cnt  in  CNT_W  live timer count
tim_evt  in  1  timer overflow/underflow indication (level; may last several cycles)
cap_in  in  1  external capture trigger (used only with the optional feature)
irq  out  1  combined interrupt, level

Behaviour:
- Register map (word address):
  - 0 CR: b0 CEN, b1 DIR, b2 OPM, b3 ARPE.
  - 1 DIER: b0 UIE, b1 CCIE.
  - 2 SR: b0 UIF, b1 CCIF. Write-1-to-clear.
  - 3 EGR: b0 UG. Write-only; reads 0.
  - 4 PSC, 5 ARR, 6 CNT (read-only mirror of tim_cnt), 7 CCR (read-only).
  - Unused bits read 0. Writes to read-only registers are ignored.
- Writes take effect at the clock edge that samples bus_sel & bus_we.
- Reads: bus_rdata and bus_rvalid are valid in the following cycle. bus_rdata holds its value until the next read.
- Reset values:
  - All control and status registers 0. PSC = PSC_RST, ARR = ARR_RST.
  - bus_rdata 0, bus_rvalid 0, tim_en 0, tim_reload 0, irq 0. FSM in IDLE.
  - The tim_evt history register resets to 1, so a high tim_evt at reset release is not counted as an edge.
- Update event (UEV): rising edge of tim_evt, or a write of 1 to EGR.UG. It is acted on at the same clock edge it is detected:
  - Set UIF.
  - Copy PSC preload to active.
  - Copy ARR preload to active.
  - If OPM=1, clear CEN.
  - UG additionally pulses tim_reload for one cycle.
- PSC is always preloaded; the active value changes only on a UEV or on entry to ARM.
- ARR with ARPE=0: the active value follows a preload write at the next edge. With ARPE=1: it changes only on a UEV or ARM.
- FSM:
  - IDLE: tim_en=0. Goes to ARM when CEN becomes 1.
  - ARM: lasts exactly one cycle. tim_reload=1; PSC and ARR active registers are loaded from preload. Goes to RUN, or to IDLE if CEN was cleared in that cycle.
  - RUN: tim_en=1. Goes to IDLE in the cycle after CEN becomes 0 (software write or OPM). tim_en is low in that cycle.
- A UEV while in IDLE still sets UIF and transfers the shadow values.
- irq = (UIF & UIE) | (CCIF & CCIE), driven from registers.
- Simultaneous events:
  - A flag set and a W1C clear of the same flag in one cycle: set wins.
  - A software CEN write and an OPM clear in one cycle: the clear wins.
  - A PSC or ARR write in the same cycle as a UEV: the write lands in preload after the transfer. The active register gets the old preload; the new value applies at the next UEV.
- rst asserted mid-operation: all state returns to reset values at the next edge. tim_reload is not pulsed.

Optional Feature:
TIM_CTRL_CAPTURE_EN
- With the macro defined:
  - cap_in passes through a 2-flop synchronizer followed by rising-edge detection.
  - On an edge, CCR latches tim_cnt and CCIF is set.
  - A capture while CCIF is already set overwrites CCR.
- Without the macro: cap_in is ignored, CCR and CCIF read 0, and no capture logic is present.

Test Plan:
- Reset, then read all 8 addresses -> CR/DIER/SR/EGR/CNT/CCR = 0, PSC = 0, ARR = 0xFFFF. bus_rvalid 1 cycle after each strobe.
- Write PSC = 9, ARR = 99, then CR = 0x1 -> tim_reload high exactly 1 cycle (ARM) with tim_psc = 9, tim_arr = 99. tim_en = 1 from the next cycle.
- With ARPE = 1, running: write ARR = 50 -> tim_arr stays 99 until a tim_evt rising edge, then 50. Hold tim_evt high 4 cycles -> UIF sets once.
- OPM = 1, CEN = 1, UIE = 1, pulse tim_evt -> UIF = 1, irq = 1, CEN reads 0, tim_en low the cycle after. Write SR = 0x1 -> irq drops the next cycle.
- W1C to UIF in the same cycle as a tim_evt edge -> UIF remains 1. EGR = 1 -> tim_reload pulse, UIF = 1, EGR reads 0.
- Capture (macro on): tim_cnt = 0x1234, raise cap_in -> after the sync delay CCR = 0x1234 and CCIF = 1; with CCIE = 1, irq = 1. Macro off -> CCR stays 0.
